// File: rtl/multi_byte_add_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// multi_byte_add_ctrl_pkg
//
// Shared definitions for the multi-byte add/subtract sequencer:
//   state_t      - controller state encoding (IDLE / RUN / DONE)
//   BYTE_W       - width of the shared adder datapath
//   signed_ovf() - two's-complement overflow test on the top byte
// -----------------------------------------------------------------------------
package multi_byte_add_ctrl_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Signed overflow of an add: both operands share a sign and the sum's
    // sign differs from it. For subtract, b_msb must be the inverted operand.
    function automatic logic signed_ovf(input logic a_msb,
                                        input logic b_msb,
                                        input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/multi_byte_add_ctrl_if.sv
// -----------------------------------------------------------------------------
// multi_byte_add_ctrl_if
//
// Request/response bundle between a requesting unit and the sequencer.
//   start    - request pulse (requester -> sequencer)
//   sub      - 0: a+b, 1: a-b (sampled with start)
//   op_a     - operand A, W bits (sampled with start)
//   op_b     - operand B, W bits (sampled with start)
//   busy     - high while the sequencer is stepping through bytes
//   done     - one-cycle pulse, result/cout/overflow valid
//   result   - W-bit sum/difference
//   cout     - final carry (subtract: 1 = no borrow)
//   overflow - signed overflow of the full-width operation
// Modports: master = requester, slave = sequencer.
// -----------------------------------------------------------------------------
interface multi_byte_add_ctrl_if
    import multi_byte_add_ctrl_pkg::*;
#(
    parameter int NBYTES = 4
);

    localparam int W = BYTE_W * NBYTES;

    logic         start;
    logic         sub;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;

    modport master (
        output start, sub, op_a, op_b,
        input  busy, done, result, cout, overflow
    );

    modport slave (
        input  start, sub, op_a, op_b,
        output busy, done, result, cout, overflow
    );

endinterface

// File: rtl/eight_bit_full_adder.sv
// -----------------------------------------------------------------------------
// eight_bit_full_adder
//
// Combinational 8-bit ripple-carry adder.
//   a, b  - 8-bit addends
//   cin   - carry in
//   sum   - 8-bit sum
//   cout  - carry out of bit 7
// -----------------------------------------------------------------------------
module eight_bit_full_adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    always_comb begin
        logic carry;
        carry = cin;
        sum   = '0;
        for (int i = 0; i < 8; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/multi_byte_add_ctrl.sv
// -----------------------------------------------------------------------------
// multi_byte_add_ctrl
//
// Performs NBYTES-wide add/subtract by stepping one shared 8-bit adder over
// the operands, least-significant byte first, one byte per clock. The carry
// between bytes is held in a register. Subtract is a + ~b + 1, with the +1
// entering as the initial carry.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - multi_byte_add_ctrl_if.slave (start/sub/op_a/op_b in,
//          busy/done/result/cout/overflow out)
//
// Timing: start accepted at edge T -> busy for NBYTES cycles -> done pulse in
// the following cycle. A start in the DONE cycle is accepted back-to-back;
// a start during RUN is ignored.
// -----------------------------------------------------------------------------
module multi_byte_add_ctrl
    import multi_byte_add_ctrl_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    multi_byte_add_ctrl_if.slave bus
);

    localparam int W     = BYTE_W * NBYTES;
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    // FSM
    state_t state_q;
    state_t state_d;
    logic   accept;
    logic   last_byte;

    // Latched operands (data only, not reset)
    logic [W-1:0] a_l;
    logic [W-1:0] b_l;
    logic         sub_l;

    // Sequencing control
    logic [IDX_W-1:0] idx;
    logic             carry_reg;

    // Output registers
    logic [W-1:0] result_q;
    logic         busy_q;
    logic         done_q;
    logic         cout_q;
    logic         ovf_q;

    // Byte datapath around the shared adder
    logic [IDX_W+2:0]    bit_off;
    logic [BYTE_W-1:0]   a_byte;
    logic [BYTE_W-1:0]   b_eff;
    logic [BYTE_W-1:0]   sum_byte;
    logic                add_cout;

    // Byte lane select: idx * 8 as a shift to keep the index expression narrow.
    assign bit_off = {idx, 3'b000};
    assign a_byte  = a_l[bit_off +: BYTE_W];
    assign b_eff   = b_l[bit_off +: BYTE_W] ^ {BYTE_W{sub_l}};

    eight_bit_full_adder u_adder (
        .a    (a_byte),
        .b    (b_eff),
        .cin  (carry_reg),
        .sum  (sum_byte),
        .cout (add_cout)
    );

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        last_byte = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (idx == LAST_IDX) begin
                    last_byte = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // State, control and result registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            idx       <= '0;
            carry_reg <= 1'b0;
        end else begin
            state_q <= state_d;
            // busy/done are registered decodes of the next state so they
            // line up exactly with RUN and DONE.
            busy_q  <= (state_d == RUN);
            done_q  <= (state_d == DONE);

            if (accept) begin
                // Subtract seeds the carry with 1 to complete a + ~b + 1.
                carry_reg <= bus.sub;
                idx       <= '0;
                result_q  <= '0;
                cout_q    <= 1'b0;
                ovf_q     <= 1'b0;
            end else if (state_q == RUN) begin
                result_q[bit_off +: BYTE_W] <= sum_byte;
                carry_reg                   <= add_cout;
                idx                         <= idx + 1'b1;
                if (last_byte) begin
                    cout_q <= add_cout;
                    ovf_q  <= signed_ovf(a_byte[BYTE_W-1], b_eff[BYTE_W-1],
                                         sum_byte[BYTE_W-1]);
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Operand capture
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept) begin
            a_l   <= bus.op_a;
            b_l   <= bus.op_b;
            sub_l <= bus.sub;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_multi_byte_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multi_byte_add_ctrl
//
// Scoreboard bench for multi_byte_add_ctrl with NBYTES = 4. Expected results
// are queued when a start is issued and compared when done pulses.
// -----------------------------------------------------------------------------
module tb_multi_byte_add_ctrl;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         o;
    } exp_t;

    logic clk;
    logic rst;

    multi_byte_add_ctrl_if #(.NBYTES(NB)) bus ();

    multi_byte_add_ctrl #(.NBYTES(NB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks;
    int   n_errors;
    int   done_cnt;
    exp_t sb_q[$];
    exp_t mon_e;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Independent full-width reference: a + b, or a + ~b + 1 for subtract.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t         e;
        logic [W-1:0] be;
        logic [W:0]   f;
        be  = s ? ~b : b;
        f   = {1'b0, a} + {1'b0, be} + (W + 1)'(s);
        e.r = f[W-1:0];
        e.c = f[W];
        e.o = (a[W-1] == be[W-1]) && (f[W-1] != a[W-1]);
        return e;
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("result",   64'(bus.result),   64'(mon_e.r));
                check("cout",     64'(bus.cout),     64'(mon_e.c));
                check("overflow", 64'(bus.overflow), 64'(mon_e.o));
            end
        end
    end

    // Called just after a negedge; start is seen at the next posedge.
    // Returns at the following negedge (first cycle after acceptance).
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic push, input exp_t e);
        bus.op_a  = a;
        bus.op_b  = b;
        bus.sub   = s;
        bus.start = 1'b1;
        if (push) sb_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Starting at the first negedge after acceptance (cycle T+1), counts
    // cycles until done and how many of them had busy high.
    task automatic wait_done(output int lat, output int nbusy);
        lat   = 1;
        nbusy = bus.busy ? 1 : 0;
        while (!bus.done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.busy) nbusy++;
        end
        if (!bus.done) check("done_timeout", 64'd0, 64'd1);
    endtask

    function automatic exp_t mk(input logic [W-1:0] r, input logic c, input logic o);
        exp_t e;
        e.r = r;
        e.c = c;
        e.o = o;
        return e;
    endfunction

    initial begin
        int           lat;
        int           nb;
        int           dc;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;

        n_checks  = 0;
        n_errors  = 0;
        done_cnt  = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;

        repeat (3) @(negedge clk);
        check("rst_busy",     64'(bus.busy),     64'd0);
        check("rst_done",     64'(bus.done),     64'd0);
        check("rst_result",   64'(bus.result),   64'd0);
        check("rst_cout",     64'(bus.cout),     64'd0);
        check("rst_overflow", 64'(bus.overflow), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: byte carry propagation, latency and busy width
        issue(32'h000000FF, 32'h00000001, 1'b0, 1'b1, mk(32'h00000100, 1'b0, 1'b0));
        wait_done(lat, nb);
        check("done_latency", 64'(lat), 64'd5);
        check("busy_cycles",  64'(nb),  64'd4);
        @(negedge clk);

        // 2: full carry out, then signed overflow on add
        issue(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, mk(32'h00000000, 1'b1, 1'b0));
        wait_done(lat, nb);
        @(negedge clk);
        issue(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, mk(32'h80000000, 1'b0, 1'b1));
        wait_done(lat, nb);
        @(negedge clk);

        // 3: borrow, then signed overflow on subtract
        issue(32'h00000005, 32'h00000007, 1'b1, 1'b1, mk(32'hFFFFFFFE, 1'b0, 1'b0));
        wait_done(lat, nb);
        @(negedge clk);
        issue(32'h80000000, 32'h00000001, 1'b1, 1'b1, mk(32'h7FFFFFFF, 1'b1, 1'b1));
        wait_done(lat, nb);
        @(negedge clk);

        // 4: start during RUN must be ignored
        dc = done_cnt;
        issue(32'h12345678, 32'h11111111, 1'b0, 1'b1, mk(32'h23456789, 1'b0, 1'b0));
        bus.op_a  = 32'hDEADBEEF;
        bus.op_b  = 32'h0BADF00D;
        bus.sub   = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        check("ignored_start_done_count", 64'(done_cnt - dc), 64'd1);

        // 5: back-to-back, second start during DONE
        issue(32'h00000003, 32'h00000004, 1'b0, 1'b1, mk(32'h00000007, 1'b0, 1'b0));
        wait_done(lat, nb);
        issue(32'h00000001, 32'h00000001, 1'b0, 1'b1, mk(32'h00000002, 1'b0, 1'b0));
        check("b2b_busy", 64'(bus.busy), 64'd1);
        wait_done(lat, nb);
        check("b2b_gap", 64'(lat), 64'd5);
        @(negedge clk);

        // 6: reset mid-operation aborts without a done pulse
        dc = done_cnt;
        issue(32'hCAFEF00D, 32'h01020304, 1'b0, 1'b0, mk('0, 1'b0, 1'b0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy",     64'(bus.busy),     64'd0);
        check("abort_done",     64'(bus.done),     64'd0);
        check("abort_result",   64'(bus.result),   64'd0);
        check("abort_cout",     64'(bus.cout),     64'd0);
        check("abort_overflow", 64'(bus.overflow), 64'd0);
        repeat (8) @(negedge clk);
        check("abort_no_done", 64'(done_cnt - dc), 64'd0);
        issue(32'h0000000A, 32'h00000005, 1'b0, 1'b1, mk(32'h0000000F, 1'b0, 1'b0));
        wait_done(lat, nb);
        @(negedge clk);

        // Random operations against the full-width model
        for (int i = 0; i < 12; i++) begin
            ra = $urandom();
            rb = $urandom();
            rs = 1'($urandom_range(0, 1));
            issue(ra, rb, rs, 1'b1, model(ra, rb, rs));
            wait_done(lat, nb);
            @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multi_byte_add_ctrl.md
Name: multi_byte_add_ctrl

Overview:
Sequencer that performs NBYTES-wide add/subtract by time-multiplexing one instance of the existing 8-bit ripple adder, eight_bit_full_adder. It processes one byte per cycle, LSB first, and keeps the inter-byte carry in a register. It sits between a requesting unit (start/done handshake) and the shared 8-bit adder datapath. It gives wide arithmetic without widening the adder.

Parameters:
NBYTES, 4, number of bytes per operand (legal range 2..16); operand width W = 8*NBYTES

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request pulse; accepted only when not busy
sub  input  1  0 = a+b, 1 = a-b; sampled with start
op_a  input  W  operand A; sampled with start
op_b  input  W  operand B; sampled with start
busy  output  1  high while an operation is in RUN
done  output  1  one-cycle pulse: result/cout/overflow valid
result  output  W  sum/difference register
cout  output  1  final carry out (subtract: 1 = no borrow, i.e. a >= b unsigned)
overflow  output  1  two's-complement signed overflow of the full-width op

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). All state and outputs are registered.
- Reset values:
  - state = IDLE
  - busy = 0, done = 0, result = 0, cout = 0, overflow = 0
  - internal byte index = 0, carry register = 0
- States:
  - IDLE: wait for start.
  - RUN: one byte per cycle.
  - DONE: single cycle; done = 1.
- Accept condition: start is accepted when state is IDLE or DONE (back-to-back ops allowed). start while in RUN is ignored, with no effect on the op in flight.
- On accept:
  - Latch op_a, op_b and sub into internal registers.
  - carry_reg <= sub; idx <= 0; result <= 0; cout <= 0; overflow <= 0.
  - Next state RUN.
- RUN, each cycle, driving the adder with:
  - a = A[idx*8 +: 8]
  - b = B[idx*8 +: 8] XOR {8{sub_l}}
  - cin = carry_reg
- RUN, each cycle, registered updates:
  - result[idx*8 +: 8] <= adder sum
  - carry_reg <= adder cout
  - idx <= idx+1
- Leaving RUN: when idx == NBYTES-1, also register:
  - cout <= adder cout
  - overflow <= (a[7] == b_eff[7]) && (sum[7] != a[7]), where b_eff is the inverted operand when sub = 1
  - Next state DONE.
- DONE: done = 1 for exactly one cycle. Next state is RUN if start is asserted that cycle (new op accepted), else IDLE.
- busy = 1 exactly in RUN.
- Latency: start accepted at edge T → busy high for cycles T+1..T+NBYTES → done high in cycle T+NBYTES+1.
- Outputs hold after DONE: result, cout and overflow stay stable until the next accepted start.
- During RUN, result holds a partially updated value and is only valid when done = 1.
- Arithmetic is modulo 2^W. No saturation.
- Reset mid-operation: the op is aborted and all outputs return to reset values on the next edge. No done pulse is issued.
- rst has priority over start in the same cycle.

Decomposition:
- Shared package:
  - State encoding constants: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2.
  - BYTE_W = 8.
- Index width: $clog2(NBYTES), computed locally.
- Sub-module: one instance of the existing eight_bit_full_adder (ports a, b, cin, sum, cout). No new sub-module is needed.
- The controller is the FSM, the operand/carry registers and the byte muxing.

Test Plan:
(All cases NBYTES = 4; start accepted at edge T.)
1. Add 0x000000FF + 0x00000001 → done at T+5, result = 0x00000100, cout = 0, overflow = 0. busy high for exactly 4 cycles.
2. Add 0xFFFFFFFF + 0x00000001 → result = 0x00000000, cout = 1, overflow = 0. Then add 0x7FFFFFFF + 0x00000001 → result = 0x80000000, cout = 0, overflow = 1.
3. Sub 0x00000005 - 0x00000007 → result = 0xFFFFFFFE, cout = 0, overflow = 0. Then sub 0x80000000 - 0x00000001 → result = 0x7FFFFFFF, cout = 1, overflow = 1.
4. Op 0x12345678 + 0x11111111 → result = 0x23456789. start is pulsed in cycles T+2 with different operands; it is ignored, the result is unchanged and only one done pulse occurs.
5. Back-to-back: start asserted in the DONE cycle with 0x00000001 + 0x00000001 → busy rises the next cycle, second done 5 cycles after the first, result = 0x00000002.
6. rst asserted at T+2 mid-RUN → next cycle busy = 0, done = 0, result = 0, cout = 0, overflow = 0, and no done pulse follows. A subsequent add 0x0000000A + 0x00000005 → result = 0x0000000F.
